// File: rtl/rd_ptr_empty_ctrl.sv
// ---------------------------------------------------------------------------
// rd_ptr_empty_ctrl
//   Read-side pointer and flag controller for an asynchronous FIFO. It keeps a
//   binary/Gray read pointer pair and decodes the already-synchronised Gray
//   write pointer. From these it produces the registered empty, almost_empty
//   and occupancy flags, plus read acknowledge and underflow pulses.
//
// Parameters
//   ADDR_WIDTH  FIFO address width; depth = 2**ADDR_WIDTH
//   AE_THRESH   almost-empty threshold in entries (0 <= AE_THRESH < depth)
//
// Ports
//   read_clk         in   read-domain clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   rd_en            in   read request
//   synch_write_ptr  in   Gray write pointer, already in the read_clk domain
//   read_addr        out  RAM read address (low bits of binary read pointer)
//   read_ptr_gray    out  registered Gray read pointer for the write side
//   empty            out  registered empty flag
//   almost_empty     out  registered flag, occupancy <= AE_THRESH
//   rd_count         out  registered occupancy, 0 .. 2**ADDR_WIDTH
//   rd_ack           out  pulse one clock after an accepted read
//   underflow        out  pulse one clock after a rejected read
// ---------------------------------------------------------------------------
module rd_ptr_empty_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AE_THRESH  = 2
) (
  input  logic                  read_clk,
  input  logic                  rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   synch_write_ptr,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [ADDR_WIDTH:0]   read_ptr_gray,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  rd_ack,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] wbin;
  logic [PW-1:0] diff_next;
  logic          rd_inc;

  // Reads are gated by the registered empty, so a write-pointer change in the
  // same cycle cannot let a read through a flag that has not updated yet.
  assign rd_inc     = rd_en & ~empty;
  assign rbin_next  = rbin + PW'(rd_inc);
  assign rgray_next = rbin_next ^ (rbin_next >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above
  // it, which equals the chained XOR with the next-higher decoded bit.
  always_comb begin
    wbin = '0;
    for (int i = 0; i < PW; i++) begin
      wbin[i] = ^(synch_write_ptr >> i);
    end
  end

  // Modulo-2**PW difference; a full FIFO shows up as exactly 2**ADDR_WIDTH.
  assign diff_next = wbin - rbin_next;

  // NOTE: all state is updated with non-blocking assignments so every flag
  // below sees the same pre-edge values and no ordering hazard exists between
  // the pointer and the flags derived from its next value.
  always_ff @(posedge read_clk or negedge rst_n) begin
    if (!rst_n) begin
      rbin          <= '0;
      read_ptr_gray <= '0;
      empty         <= 1'b1;
      almost_empty  <= 1'b1;
      rd_count      <= '0;
      rd_ack        <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      rbin          <= rbin_next;
      read_ptr_gray <= rgray_next;
      // Comparing against the next Gray pointer makes empty assert on the
      // same edge that consumes the last entry.
      empty         <= (rgray_next == synch_write_ptr);
      almost_empty  <= (diff_next <= AE_LIMIT);
      rd_count      <= diff_next;
      rd_ack        <= rd_inc;
      underflow     <= rd_en & empty;
    end
  end

  assign read_addr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_rd_ptr_empty_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rd_ptr_empty_ctrl
//   Directed self-checking bench for rd_ptr_empty_ctrl (ADDR_WIDTH=4,
//   AE_THRESH=2). Each scenario task drives stimulus and compares a snapshot
//   of all outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_rd_ptr_empty_ctrl;

  logic       read_clk;
  logic       rst_n;
  logic       rd_en;
  logic [4:0] synch_write_ptr;
  logic [3:0] read_addr;
  logic [4:0] read_ptr_gray;
  logic       empty;
  logic       almost_empty;
  logic [4:0] rd_count;
  logic       rd_ack;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  rd_ptr_empty_ctrl #(.ADDR_WIDTH(4), .AE_THRESH(2)) dut (
    .read_clk        (read_clk),
    .rst_n           (rst_n),
    .rd_en           (rd_en),
    .synch_write_ptr (synch_write_ptr),
    .read_addr       (read_addr),
    .read_ptr_gray   (read_ptr_gray),
    .empty           (empty),
    .almost_empty    (almost_empty),
    .rd_count        (rd_count),
    .rd_ack          (rd_ack),
    .underflow       (underflow)
  );

  initial read_clk = 1'b0;
  always #5 read_clk = ~read_clk;

  // Snapshot layout: addr[17:14] gray[13:9] empty[8] ae[7] count[6:2] ack[1] uf[0]
  function automatic logic [17:0] snap();
    return {read_addr, read_ptr_gray, empty, almost_empty, rd_count, rd_ack, underflow};
  endfunction

  function automatic logic [17:0] pack(input logic [3:0] a, input logic [4:0] g,
                                       input logic e, input logic ae,
                                       input logic [4:0] c, input logic ack,
                                       input logic uf);
    return {a, g, e, ae, c, ack, uf};
  endfunction

  // Advance one edge and sample 1 ns later, away from the edge.
  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    logic [17:0] exp;
    rst_n = 1'b0;
    rd_en = 1'b0;
    synch_write_ptr = 5'b00000;
    tick();
    tick();
    obs = snap();
    exp = pack(4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_held: got %b want %b", obs, exp);
    end
    @(negedge read_clk);
    rst_n = 1'b1;
    tick();
    obs = snap();
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_release_idle: got %b want %b", obs, exp);
    end
  endtask

  task automatic test_fill_and_drain();
    logic [17:0] obs;
    logic [17:0] exp [4];
    synch_write_ptr = 5'b00010;  // gray(3)
    tick();
    obs = snap();
    checks++;
    if (obs !== pack(4'd0, 5'b00000, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL fill_3: got %b want %b", obs,
               pack(4'd0, 5'b00000, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0));
    end
    exp[0] = pack(4'd1, 5'b00001, 1'b0, 1'b1, 5'd2, 1'b1, 1'b0);
    exp[1] = pack(4'd2, 5'b00011, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0);
    exp[2] = pack(4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    // Fourth request lands on an empty FIFO and must be rejected.
    exp[3] = pack(4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    rd_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      obs = snap();
      checks++;
      if (obs !== exp[k]) begin
        failures++;
        $display("FAIL drain_step%0d: got %b want %b", k, obs, exp[k]);
      end
    end
    rd_en = 1'b0;
    tick();
    obs = snap();
    checks++;
    if (obs !== pack(4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL underflow_one_cycle: got %b want %b", obs,
               pack(4'd3, 5'b00010, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_wrap_full();
    logic [17:0] obs;
    logic [4:0]  prev_gray;
    logic [4:0]  b;
    logic [4:0]  g;
    logic [4:0]  cnt;
    synch_write_ptr = 5'b11010;  // gray(19): 16 entries beyond rbin=3
    tick();
    obs = snap();
    checks++;
    if (obs !== pack(4'd3, 5'b00010, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL full_16: got %b want %b", obs,
               pack(4'd3, 5'b00010, 1'b0, 1'b0, 5'd16, 1'b0, 1'b0));
    end
    rd_en = 1'b1;
    prev_gray = read_ptr_gray;
    for (int k = 1; k <= 16; k++) begin
      tick();
      b   = 5'(3 + k);
      g   = b ^ (b >> 1);
      cnt = 5'(16 - k);
      obs = snap();
      checks++;
      if (obs !== pack(b[3:0], g, (cnt == 5'd0), (cnt <= 5'd2), cnt, 1'b1, 1'b0)) begin
        failures++;
        $display("FAIL wrap_read%0d: got %b want %b", k, obs,
                 pack(b[3:0], g, (cnt == 5'd0), (cnt <= 5'd2), cnt, 1'b1, 1'b0));
      end
      checks++;
      if ($countones(prev_gray ^ read_ptr_gray) != 1) begin
        failures++;
        $display("FAIL gray_one_bit%0d: got %b -> %b want single-bit step",
                 k, prev_gray, read_ptr_gray);
      end
      prev_gray = read_ptr_gray;
    end
    rd_en = 1'b0;
    checks++;
    if (read_ptr_gray !== 5'b11010 || empty !== 1'b1) begin
      failures++;
      $display("FAIL wrap_final: got gray=%b empty=%b want gray=11010 empty=1",
               read_ptr_gray, empty);
    end
  endtask

  task automatic test_async_reset();
    logic [17:0] obs;
    logic [17:0] rst_exp;
    rst_exp = pack(4'd0, 5'b00000, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    synch_write_ptr = 5'b10111;  // gray(26): 7 entries beyond rbin=19
    tick();
    rd_en = 1'b1;
    tick();
    tick();
    obs = snap();
    checks++;
    if (obs !== pack(4'd5, 5'b11111, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL pre_reset_count5: got %b want %b", obs,
               pack(4'd5, 5'b11111, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0));
    end
    // Drop reset between edges, well before the next rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    obs = snap();
    checks++;
    if (obs !== rst_exp) begin
      failures++;
      $display("FAIL async_reset_immediate: got %b want %b", obs, rst_exp);
    end
    // rd_en stays high across an edge in reset: nothing may be accepted.
    tick();
    obs = snap();
    checks++;
    if (obs !== rst_exp) begin
      failures++;
      $display("FAIL reset_blocks_reads: got %b want %b", obs, rst_exp);
    end
    rd_en = 1'b0;
    synch_write_ptr = 5'b00011;  // gray(2)
    @(negedge read_clk);
    rst_n = 1'b1;
    tick();
    obs = snap();
    checks++;
    if (obs !== pack(4'd0, 5'b00000, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0)) begin
      failures++;
      $display("FAIL resume_fill: got %b want %b", obs,
               pack(4'd0, 5'b00000, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0));
    end
    rd_en = 1'b1;
    tick();
    obs = snap();
    checks++;
    if (obs !== pack(4'd1, 5'b00001, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL resume_read0: got %b want %b", obs,
               pack(4'd1, 5'b00001, 1'b0, 1'b1, 5'd1, 1'b1, 1'b0));
    end
  endtask

  task automatic test_same_cycle();
    logic [17:0] obs;
    tick();  // consumes the last entry: rbin=2, empty
    obs = snap();
    checks++;
    if (obs !== pack(4'd2, 5'b00011, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0)) begin
      failures++;
      $display("FAIL drain_to_empty: got %b want %b", obs,
               pack(4'd2, 5'b00011, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0));
    end
    // Read and a new write pointer arrive together: read is gated by the old
    // empty, flags reflect the new write pointer.
    synch_write_ptr = 5'b00010;  // gray(3)
    tick();
    obs = snap();
    checks++;
    if (obs !== pack(4'd2, 5'b00011, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1)) begin
      failures++;
      $display("FAIL same_cycle_write: got %b want %b", obs,
               pack(4'd2, 5'b00011, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1));
    end
    rd_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_and_drain();
    test_wrap_full();
    test_async_reset();
    test_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rd_ptr_empty_ctrl.md
RD_PTR_EMPTY_CTRL -- requirements
Module: rd_ptr_empty_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, which sets the FIFO address width (depth = 2**ADDR_WIDTH).
REQ-002 The block SHALL have parameter AE_THRESH, default 2, the almost-empty threshold in entries (0 <= AE_THRESH < 2**ADDR_WIDTH).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; there SHALL be no other clock or reset.
REQ-004 read_clk  in  1  read-domain clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 rd_en  in  1  read request.
REQ-007 synch_write_ptr  in  ADDR_WIDTH+1  write pointer, Gray-coded, already synchronised into read_clk.
REQ-008 read_addr  out  ADDR_WIDTH  memory read address, the low bits of the binary read pointer.
REQ-009 read_ptr_gray  out  ADDR_WIDTH+1  registered Gray read pointer for the write-domain synchroniser.
REQ-010 empty  out  1  registered empty flag.
REQ-011 almost_empty  out  1  registered flag; 1 when rd_count <= AE_THRESH.
REQ-012 rd_count  out  ADDR_WIDTH+1  registered occupancy seen from the read side, range 0..2**ADDR_WIDTH.
REQ-013 rd_ack  out  1  one-cycle pulse, one clock after an accepted read (data valid from registered RAM).
REQ-014 underflow  out  1  one-cycle pulse, one clock after a rejected read.

Function
REQ-015 The block SHALL accept a read when rd_inc = rd_en & ~empty, using the registered empty.
REQ-016 The block SHALL compute rbin_next = rbin + rd_inc, modulo 2**(ADDR_WIDTH+1); the pointer wraps without saturation.
REQ-017 The block SHALL compute rgray_next = rbin_next ^ (rbin_next >> 1) and register rbin_next and rgray_next on every clock edge.
REQ-018 read_ptr_gray SHALL change in at most one bit per clock.
REQ-019 The block SHALL decode synch_write_ptr Gray to binary wbin combinationally, with the MSB unchanged and each lower bit the XOR of itself with the next-higher decoded bit.
REQ-020 The block SHALL register empty <= (rgray_next == synch_write_ptr), so empty asserts on the same edge that consumes the last entry.
REQ-021 empty SHALL deassert on the first edge after synch_write_ptr differs from the current read pointer; there SHALL be no extra latency beyond the external synchroniser.
REQ-022 The block SHALL register rd_count <= (wbin - rbin_next), modulo 2**(ADDR_WIDTH+1); a value of 2**ADDR_WIDTH means full.
REQ-023 The block SHALL register almost_empty <= ((wbin - rbin_next) <= AE_THRESH), using the same modulo difference.
REQ-024 The block SHALL register rd_ack <= rd_inc.
REQ-025 The block SHALL register underflow <= rd_en & empty.
REQ-026 On a rejected read, the pointer, read_addr and read_ptr_gray SHALL hold.
REQ-027 When rd_en and a write-pointer change arrive in the same cycle, the read SHALL be gated by the old empty, and the flags SHALL use the new synch_write_ptr and rbin_next.
REQ-028 empty, almost_empty and rd_count SHALL remain mutually consistent every cycle: empty = 1 exactly when rd_count = 0.
REQ-029 The block SHALL be a plain counter/flag datapath with no FSM and no latches.

Reset
REQ-030 When rst_n = 0, outputs SHALL asynchronously take these values: rbin = 0, read_addr = 0, read_ptr_gray = 0, empty = 1, almost_empty = 1, rd_count = 0, rd_ack = 0, underflow = 0.
REQ-031 The block SHALL release reset synchronously to read_clk via an external reset synchroniser; the first update occurs on the first edge with rst_n = 1.
REQ-032 A reset asserted mid-operation SHALL discard all pointer state; no accepted read SHALL occur while rst_n = 0.

Verification (ADDR_WIDTH=4, AE_THRESH=2)
REQ-033 Reset, synch_write_ptr = 00000 -> empty = 1, almost_empty = 1, rd_count = 0, read_ptr_gray = 00000.
REQ-034 Drive synch_write_ptr = 00010 (bin 3), with no rd_en -> the next edge gives empty = 0, rd_count = 3, almost_empty = 0.
REQ-035 Then hold rd_en high for 3 cycles -> read_addr = 0, 1, 2, 3; rd_count = 2, 1, 0; almost_empty = 1 after the first read; empty = 1 on the third edge; rd_ack high for 3 cycles.
REQ-036 A 4th rd_en while empty -> underflow = 1 for one cycle, rd_ack = 0, read_addr stays 3.
REQ-037 Wrap and full: from rbin = 3, set synch_write_ptr = gray(19) = 11010 -> rd_count = 16; then 16 reads -> read_ptr_gray = 11010, empty = 1, and every Gray step changes exactly 1 bit.
REQ-038 Drop rst_n asynchronously mid-burst, between edges, with rd_count = 5 -> all outputs reach their reset values before the next edge, and reads resume from read_addr = 0 after release.
